// File: rtl/ras_spill_mem.sv
// Memory-side responder for the RAS spill/fill path: fixed-latency word array with valid bitmap and sticky errors.
// Optional even-parity protection per word is enabled by defining RAS_SPILL_PARITY_EN.
module ras_spill_mem #(
  parameter int W     = 32,
  parameter int DEPTH = 256,
  parameter int LAT   = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_rd,
  input  logic                     req_wr,
  input  logic [31:0]              req_addr,
  input  logic [W-1:0]             req_din,
  output logic                     req_rdy,
  output logic [W-1:0]             rsp_dout,
  output logic                     rsp_valid,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     err_align,
  output logic                     err_oob,
  output logic                     err_uninit,
  output logic                     err_conflict,
  input  logic                     clr_err,
`ifdef RAS_SPILL_PARITY_EN
  input  logic                     inj_parity,
  output logic                     err_parity,
`endif
  output logic [1:0]               dbg_state
);

  // Handshake: a request is taken on any clk edge where req_rdy && (req_rd || req_wr);
  // inputs are sampled only then. A read answers with a one-cycle rsp_valid LAT cycles later.

  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_LOAD = 4'(LAT > 1 ? LAT - 2 : 0);
  localparam logic [AW:0] OCC_ONE = (AW+1)'(1);
  localparam bit DIRECT = (LAT == 1);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  state_t           state_q, state_nx;
  logic [3:0]       cnt_q;
  logic [W-1:0]     mem [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic             pend_rd_q;
  logic [W-1:0]     cap_data_q;
  logic             cap_perr_q;

  logic          accept, conflict, misalign, oob, legal, do_wr, do_rd;
  logic [AW-1:0] idx;
  logic          word_valid, rd_perr_now, cmp_busy, cmp_direct;
  logic [W-1:0]  rd_data_now;

  assign accept     = req_rdy & (req_rd | req_wr);
  assign conflict   = req_rd & req_wr;
  assign misalign   = |req_addr[1:0];
  assign oob        = {2'b00, req_addr[31:2]} >= 32'(DEPTH);
  assign legal      = accept & ~conflict & ~misalign & ~oob;
  assign do_wr      = legal & req_wr;
  assign do_rd      = legal & req_rd;
  assign idx        = req_addr[AW+1:2];
  assign word_valid = valid_q[idx];

`ifdef RAS_SPILL_PARITY_EN
  logic par_mem [DEPTH];
  logic err_parity_q;

  assign rd_perr_now = word_valid & ((^mem[idx]) != par_mem[idx]);
  assign err_parity  = err_parity_q;

  always_ff @(posedge clk) begin
    if (do_wr && !rst) par_mem[idx] <= (^req_din) ^ inj_parity;
  end

  always_ff @(posedge clk) begin
    if (rst) err_parity_q <= 1'b0;
    else err_parity_q <= (err_parity_q & ~clr_err) |
                         (cmp_busy ? cap_perr_q : (cmp_direct & rd_perr_now));
  end
`else
  assign rd_perr_now = 1'b0;
`endif

  // Unwritten or parity-corrupted words read back as zero.
  assign rd_data_now = (word_valid & ~rd_perr_now) ? mem[idx] : '0;
  assign cmp_busy    = (state_q == BUSY) && (cnt_q == 4'd0) && pend_rd_q;
  assign cmp_direct  = DIRECT && do_rd;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_nx;
      if (legal) cnt_q <= CNT_LOAD;
      else if (state_q == BUSY && cnt_q != 4'd0) cnt_q <= cnt_q - 4'd1;
    end
  end

  always_comb begin
    state_nx = state_q;
    case (state_q)
      IDLE:    if (legal) state_nx = DIRECT ? DONE : BUSY;
      BUSY:    if (cnt_q == 4'd0) state_nx = DONE;
      DONE:    state_nx = legal ? (DIRECT ? DONE : BUSY) : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_rdy   = (state_q != BUSY);
    rsp_valid = (state_q == DONE) && pend_rd_q;
    dbg_state = state_q;
  end

  always_ff @(posedge clk) begin
    if (do_wr && !rst) mem[idx] <= req_din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q      <= '0;
      occupancy    <= '0;
      pend_rd_q    <= 1'b0;
      cap_data_q   <= '0;
      cap_perr_q   <= 1'b0;
      rsp_dout     <= '0;
      err_align    <= 1'b0;
      err_oob      <= 1'b0;
      err_uninit   <= 1'b0;
      err_conflict <= 1'b0;
    end else begin
      if (do_wr) valid_q[idx] <= 1'b1;
      else if (do_rd) valid_q[idx] <= 1'b0;

      if (do_wr && !word_valid) occupancy <= occupancy + OCC_ONE;
      else if (do_rd && word_valid) occupancy <= occupancy - OCC_ONE;

      if (legal) begin
        pend_rd_q  <= req_rd;
        cap_data_q <= rd_data_now;
        cap_perr_q <= rd_perr_now;
      end

      if (cmp_busy) rsp_dout <= cap_data_q;
      else if (cmp_direct) rsp_dout <= rd_data_now;

      // A new error in the same cycle as clr_err leaves the flag set.
      err_align    <= (err_align    & ~clr_err) | (accept & misalign);
      err_oob      <= (err_oob      & ~clr_err) | (accept & oob);
      err_conflict <= (err_conflict & ~clr_err) | (accept & conflict);
      err_uninit   <= (err_uninit   & ~clr_err) | (do_rd & ~word_valid);
    end
  end

endmodule

// File: tb/tb_ras_spill_mem.sv
// Directed bench for ras_spill_mem (W=32, DEPTH=256, LAT=2) with a response scoreboard.
// Define RAS_SPILL_PARITY_EN to also exercise the parity path.
module tb_ras_spill_mem;
  localparam int W = 32;
  localparam int DEPTH = 256;
  localparam int LAT = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_rd, req_wr, clr_err;
  logic [31:0]   req_addr;
  logic [W-1:0]  req_din;
  logic          req_rdy, rsp_valid;
  logic [W-1:0]  rsp_dout;
  logic [8:0]    occupancy;
  logic          err_align, err_oob, err_uninit, err_conflict;
  logic [1:0]    dbg_state;
`ifdef RAS_SPILL_PARITY_EN
  logic          inj_parity, err_parity;
`endif

  logic [W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] d0, d4, d8, d4b, d3, d20;

  ras_spill_mem #(.W(W), .DEPTH(DEPTH), .LAT(LAT)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr), .req_addr(req_addr),
    .req_din(req_din), .req_rdy(req_rdy), .rsp_dout(rsp_dout), .rsp_valid(rsp_valid),
    .occupancy(occupancy), .err_align(err_align), .err_oob(err_oob),
    .err_uninit(err_uninit), .err_conflict(err_conflict), .clr_err(clr_err),
`ifdef RAS_SPILL_PARITY_EN
    .inj_parity(inj_parity), .err_parity(err_parity),
`endif
    .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one request for a single edge, returning at the following negedge.
  task automatic req(input logic rd, input logic wr, input logic [31:0] addr, input logic [W-1:0] din);
    req_rd = rd; req_wr = wr; req_addr = addr; req_din = din;
    @(negedge clk);
    req_rd = 1'b0; req_wr = 1'b0; req_addr = '0; req_din = '0;
  endtask

  task automatic clr_pulse();
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rsp_valid) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 64'(rsp_valid), 64'd0);
      else chk("rsp_data", 64'(rsp_dout), 64'(exp_q.pop_front()));
    end
  end

  initial begin
    rst = 1'b1; req_rd = 0; req_wr = 0; req_addr = '0; req_din = '0; clr_err = 0;
`ifdef RAS_SPILL_PARITY_EN
    inj_parity = 1'b0;
`endif
    d0  = W'($urandom_range(32'hFFFF_FFFF, 0));
    d4  = W'($urandom_range(32'hFFFF_FFFF, 0));
    d8  = W'($urandom_range(32'hFFFF_FFFF, 0)) | 32'h1;
    d4b = d4 ^ 32'h5A5A_0001;
    d3  = W'($urandom_range(32'hFFFF_FFFF, 1));
    d20 = W'($urandom_range(32'hFFFF_FFFF, 1));
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdy", 64'(req_rdy), 64'd1);
    chk("rst_valid", 64'(rsp_valid), 64'd0);
    chk("rst_dout", 64'(rsp_dout), 64'd0);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_errs", 64'({err_align, err_oob, err_uninit, err_conflict}), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'd0);

    // Spill then fill the same word.
    req(0, 1, 32'h10, 32'hBADDAB69);
    chk("t1_wr_rdy_low", 64'(req_rdy), 64'd0);
    chk("t1_wr_occ", 64'(occupancy), 64'd1);
    @(negedge clk);
    chk("t1_wr_done_state", 64'(dbg_state), 64'd2);
    chk("t1_wr_no_rsp", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    exp_q.push_back(32'hBADDAB69);
    req(1, 0, 32'h10, '0);
    chk("t1_rd_rdy_low", 64'(req_rdy), 64'd0);
    chk("t1_rd_early", 64'(rsp_valid), 64'd0);
    chk("t1_rd_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    chk("t1_rd_lat", 64'(rsp_valid), 64'd1);
    chk("t1_rd_rdy", 64'(req_rdy), 64'd1);
    @(negedge clk);
    chk("t1_pulse", 64'(rsp_valid), 64'd0);
    chk("t1_hold", 64'(rsp_dout), 64'hBADDAB69);

    // Second fill of the consumed word.
    exp_q.push_back('0);
    req(1, 0, 32'h10, '0);
    chk("t2_uninit", 64'(err_uninit), 64'd1);
    @(negedge clk);
    chk("t2_valid", 64'(rsp_valid), 64'd1);
    chk("t2_occ", 64'(occupancy), 64'd0);
    @(negedge clk);
    clr_pulse();
    chk("t2_clr", 64'(err_uninit), 64'd0);

    // Misaligned and out-of-range requests are dropped.
    req(0, 1, 32'h2, 32'h1234_5678);
    chk("t3_align", 64'(err_align), 64'd1);
    chk("t3_align_rdy", 64'(req_rdy), 64'd1);
    chk("t3_align_state", 64'(dbg_state), 64'd0);
    req(1, 0, 32'h400, '0);
    chk("t3_oob", 64'(err_oob), 64'd1);
    chk("t3_oob_rdy", 64'(req_rdy), 64'd1);
    @(negedge clk);
    chk("t3_no_rsp", 64'(rsp_valid), 64'd0);
    chk("t3_occ", 64'(occupancy), 64'd0);
    // Last legal word, with the fill issued in the DONE cycle.
    req(0, 1, 32'h3FC, d3);
    @(negedge clk);
    exp_q.push_back(d3);
    req(1, 0, 32'h3FC, '0);
    chk("t3_last_occ", 64'(occupancy), 64'd0);
    chk("t3_last_no_oob_new", 64'({err_uninit, err_conflict}), 64'd0);
    @(negedge clk);
    @(negedge clk);
    clr_pulse();

    // Conflict, back-to-back spills, overwrite.
    req(1, 1, 32'h8, 32'h1111_1111);
    chk("t4_conflict", 64'(err_conflict), 64'd1);
    chk("t4_conf_occ", 64'(occupancy), 64'd0);
    req(0, 1, 32'h0, d0);
    @(negedge clk);
    chk("t4_b2b_done0", 64'(dbg_state), 64'd2);
    req(0, 1, 32'h4, d4);
    @(negedge clk);
    chk("t4_b2b_done1", 64'(dbg_state), 64'd2);
    req(0, 1, 32'h8, d8);
    chk("t4_occ3", 64'(occupancy), 64'd3);
    @(negedge clk);
    req(0, 1, 32'h4, d4b);
    chk("t4_rewrite_occ", 64'(occupancy), 64'd3);
    @(negedge clk);
    exp_q.push_back(d4b);
    req(1, 0, 32'h4, '0);
    chk("t4_rd_occ", 64'(occupancy), 64'd2);
    @(negedge clk);
    exp_q.push_back(d8);
    req(1, 0, 32'h8, '0);
    @(negedge clk);
    @(negedge clk);
    chk("t4_final_occ", 64'(occupancy), 64'd1);

    // Reset one cycle after a fill is accepted.
    req(0, 1, 32'h1, '0);
    req(0, 1, 32'h20, d20);
    @(negedge clk);
    req(1, 0, 32'h20, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("t5_no_rsp", 64'(rsp_valid), 64'd0);
    chk("t5_rdy", 64'(req_rdy), 64'd1);
    chk("t5_occ", 64'(occupancy), 64'd0);
    chk("t5_errs", 64'({err_align, err_oob, err_uninit, err_conflict}), 64'd0);
    chk("t5_dout", 64'(rsp_dout), 64'd0);
    chk("t5_state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("t5_no_rsp2", 64'(rsp_valid), 64'd0);
    exp_q.push_back('0);
    req(1, 0, 32'h0, '0);
    chk("t5_bitmap_cleared", 64'(err_uninit), 64'd1);
    @(negedge clk);
    @(negedge clk);

`ifdef RAS_SPILL_PARITY_EN
    inj_parity = 1'b1;
    req(0, 1, 32'h40, 32'hDEADBEEF);
    inj_parity = 1'b0;
    @(negedge clk);
    exp_q.push_back('0);
    req(1, 0, 32'h40, '0);
    chk("t6_no_perr_yet", 64'(err_parity), 64'd0);
    @(negedge clk);
    chk("t6_perr", 64'(err_parity), 64'd1);
    chk("t6_valid", 64'(rsp_valid), 64'd1);
    @(negedge clk);
    req(0, 1, 32'h40, 32'hDEADBEEF);
    @(negedge clk);
    exp_q.push_back(32'hDEADBEEF);
    req(1, 0, 32'h40, '0);
    @(negedge clk);
    chk("t6_clean_dout", 64'(rsp_dout), 64'hDEADBEEF);
    chk("t6_perr_sticky", 64'(err_parity), 64'd1);
    @(negedge clk);
    clr_pulse();
    chk("t6_perr_clr", 64'(err_parity), 64'd0);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
